trigger_capture_block: RTL and testbench

Capture front end of the logic analyzer, sitting directly upstream of the FIFO that the FIFO-to-UART controller drains. It synchronises the probe inputs, waits for a qualifying edge on the masked channels, then streams samples into the FIFO write port until the FIFO reports full. It is held disarmed through `Syncrst` while the controller is reading, and it re-arms when the controller returns to IDLE.

---
 rtl/la_pkg.sv | 23 ++
 rtl/trigger_capture_block_probe_synchronizer.sv | 26 ++
 rtl/trigger_capture_block.sv | 144 ++++++++++++++
 tb/tb_trigger_capture_block.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/la_pkg.sv
// Shared logic-analyzer definitions: capture FSM state encoding and default
// probe width, also used by the FIFO-to-UART controller's debug decode.
package la_pkg;

  localparam int LA_DATA_WIDTH = 3;

  localparam logic [1:0] LA_ST_DISABLED = 2'b00;
  localparam logic [1:0] LA_ST_ARMED    = 2'b01;
  localparam logic [1:0] LA_ST_CAPTURE  = 2'b10;
  localparam logic [1:0] LA_ST_DONE     = 2'b11;

  typedef enum logic [1:0] {
    ST_DISABLED = LA_ST_DISABLED,
    ST_ARMED    = LA_ST_ARMED,
    ST_CAPTURE  = LA_ST_CAPTURE,
    ST_DONE     = LA_ST_DONE
  } la_state_e;

  function automatic logic [1:0] la_state_dbg(input la_state_e st);
    return st;
  endfunction

endpackage

// File: rtl/trigger_capture_block_probe_synchronizer.sv
// Multi-flop synchroniser for asynchronous probe pins; clears to zero on reset.
module probe_synchronizer #(
  parameter int WIDTH  = 3,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q, sync_d;

  // Stage 0 takes the pin, each later stage takes its predecessor.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/trigger_capture_block.sv
// Logic-analyzer capture front end: edge trigger on masked probes, then streams
// samples into the FIFO until full. Optional sample divider: CAPTURE_SAMPLE_DIV_EN.
module trigger_capture_block
  import la_pkg::*;
#(
  parameter int DATA_WIDTH  = LA_DATA_WIDTH,
  parameter int SYNC_STAGES = 2,
  parameter int DIV_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Syncrst,
  input  logic [DATA_WIDTH-1:0] Mask,
  input  logic                  Trig_Falling,
  input  logic [DATA_WIDTH-1:0] probe_in,
`ifdef CAPTURE_SAMPLE_DIV_EN
  input  logic [DIV_WIDTH-1:0]  Div_Value,
`endif
  input  logic                  FIFO_wrfull,
  output logic                  FIFO_wrreq,
  output logic [DATA_WIDTH-1:0] FIFO_data,
  output logic                  triggered,
  output logic [1:0]            state_debug
);

  logic [DATA_WIDTH-1:0] s;
  logic [DATA_WIDTH-1:0] s_dly_q, s_dly_d;
  logic [DATA_WIDTH-1:0] edge_vec;
  logic                  trig_hit;
  logic                  tick;

  la_state_e             state_q, state_d;
  logic                  wr_q, wr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  trig_q, trig_d;

`ifdef CAPTURE_SAMPLE_DIV_EN
  logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0]  div_lat_q, div_lat_d;
`endif

  probe_synchronizer #(
    .WIDTH  (DATA_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (probe_in),
    .q   (s)
  );

  // Edge detect runs every cycle so history is valid the moment we arm.
  always_comb begin
    s_dly_d  = s;
    edge_vec = Trig_Falling ? (~s & s_dly_q) : (s & ~s_dly_q);
    trig_hit = (|(edge_vec & Mask)) || (Mask == '0);
  end

`ifdef CAPTURE_SAMPLE_DIV_EN
  assign tick = (cnt_q == div_lat_q);
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    wr_d    = 1'b0;
    data_d  = data_q;
    trig_d  = trig_q;
`ifdef CAPTURE_SAMPLE_DIV_EN
    cnt_d     = cnt_q;
    div_lat_d = div_lat_q;
`endif
    // Disarm wins over any trigger or tick in the same cycle.
    if (Syncrst) begin
      state_d = ST_DISABLED;
      trig_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_DISABLED: state_d = ST_ARMED;
        ST_ARMED: begin
          if (trig_hit) begin
            state_d = ST_CAPTURE;
            wr_d    = 1'b1;
            data_d  = s;
            trig_d  = 1'b1;
`ifdef CAPTURE_SAMPLE_DIV_EN
            cnt_d     = '0;
            div_lat_d = Div_Value;
`endif
          end
        end
        ST_CAPTURE: begin
`ifdef CAPTURE_SAMPLE_DIV_EN
          cnt_d = tick ? '0 : cnt_q + DIV_WIDTH'(1);
`endif
          if (FIFO_wrfull) begin
            state_d = ST_DONE;
          end else if (tick) begin
            wr_d   = 1'b1;
            data_d = s;
          end
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_DISABLED;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_DISABLED;
      wr_q    <= 1'b0;
      data_q  <= '0;
      trig_q  <= 1'b0;
      s_dly_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
      trig_q  <= trig_d;
      s_dly_q <= s_dly_d;
    end
  end

`ifdef CAPTURE_SAMPLE_DIV_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      div_lat_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      div_lat_q <= div_lat_d;
    end
  end
`endif

  // Gate with the live full flag so a write is never offered to a full FIFO.
  assign FIFO_wrreq  = wr_q & ~FIFO_wrfull;
  assign FIFO_data   = data_q;
  assign triggered   = trig_q;
  assign state_debug = la_state_dbg(state_q);

endmodule

// File: tb/tb_trigger_capture_block.sv
// Directed bench for trigger_capture_block: vector table plus hand sequences.
module tb_trigger_capture_block;

  logic        clk = 1'b0;
  logic        rst;
  logic        Syncrst;
  logic [2:0]  Mask;
  logic        Trig_Falling;
  logic [2:0]  probe_in;
  logic        FIFO_wrfull;
  logic        FIFO_wrreq;
  logic [2:0]  FIFO_data;
  logic        triggered;
  logic [1:0]  state_debug;
`ifdef CAPTURE_SAMPLE_DIV_EN
  logic [15:0] Div_Value;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  trigger_capture_block dut (
    .clk          (clk),
    .rst          (rst),
    .Syncrst      (Syncrst),
    .Mask         (Mask),
    .Trig_Falling (Trig_Falling),
    .probe_in     (probe_in),
`ifdef CAPTURE_SAMPLE_DIV_EN
    .Div_Value    (Div_Value),
`endif
    .FIFO_wrfull  (FIFO_wrfull),
    .FIFO_wrreq   (FIFO_wrreq),
    .FIFO_data    (FIFO_data),
    .triggered    (triggered),
    .state_debug  (state_debug)
  );

  typedef struct {
    logic       sr;
    logic [2:0] mask;
    logic       fall;
    logic [2:0] probe;
    logic       full;
    logic       wrreq;
    logic [2:0] data;
    logic       trig;
    logic [1:0] st;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic sr, input logic [2:0] mask, input logic fall,
                              input logic [2:0] probe, input logic full, input logic wrreq,
                              input logic [2:0] data, input logic trig, input logic [1:0] st);
    vec_t v;
    v.sr = sr; v.mask = mask; v.fall = fall; v.probe = probe; v.full = full;
    v.wrreq = wrreq; v.data = data; v.trig = trig; v.st = st;
    return v;
  endfunction

  task automatic tick_chk;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            sr  mask  fl probe full | wrreq data trig st
    vecs[0]  = mk(1, 3'b010, 0, 3'b000, 0,   0, 3'b000, 0, 2'd0);
    vecs[1]  = mk(0, 3'b010, 0, 3'b000, 0,   0, 3'b000, 0, 2'd1);
    vecs[2]  = mk(0, 3'b010, 0, 3'b000, 0,   0, 3'b000, 0, 2'd1);
    vecs[3]  = mk(0, 3'b010, 0, 3'b010, 0,   0, 3'b000, 0, 2'd1);
    vecs[4]  = mk(0, 3'b010, 0, 3'b010, 0,   0, 3'b000, 0, 2'd1);
    vecs[5]  = mk(0, 3'b010, 0, 3'b110, 0,   1, 3'b010, 1, 2'd2);
    vecs[6]  = mk(0, 3'b010, 0, 3'b110, 0,   1, 3'b010, 1, 2'd2);
    vecs[7]  = mk(0, 3'b010, 0, 3'b110, 0,   1, 3'b110, 1, 2'd2);
    vecs[8]  = mk(0, 3'b010, 0, 3'b110, 1,   0, 3'b110, 1, 2'd3);
    vecs[9]  = mk(0, 3'b010, 0, 3'b110, 0,   0, 3'b110, 1, 2'd3);
    vecs[10] = mk(0, 3'b010, 0, 3'b110, 0,   0, 3'b110, 1, 2'd3);
    vecs[11] = mk(1, 3'b010, 0, 3'b110, 0,   0, 3'b110, 0, 2'd0);
    vecs[12] = mk(0, 3'b001, 1, 3'b110, 0,   0, 3'b110, 0, 2'd1);
    vecs[13] = mk(0, 3'b001, 1, 3'b010, 0,   0, 3'b110, 0, 2'd1);
    vecs[14] = mk(0, 3'b001, 1, 3'b010, 0,   0, 3'b110, 0, 2'd1);
    vecs[15] = mk(0, 3'b001, 1, 3'b010, 0,   0, 3'b110, 0, 2'd1);

    rst = 1'b1; Syncrst = 1'b1; Mask = 3'b010; Trig_Falling = 1'b0;
    probe_in = 3'b000; FIFO_wrfull = 1'b0;
`ifdef CAPTURE_SAMPLE_DIV_EN
    Div_Value = 16'd0;
`endif
    #12;
    check("rst_wrreq", FIFO_wrreq, 0);
    check("rst_data", FIFO_data, 0);
    check("rst_trig", triggered, 0);
    check("rst_state", state_debug, 0);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      Syncrst = vecs[i].sr; Mask = vecs[i].mask; Trig_Falling = vecs[i].fall;
      probe_in = vecs[i].probe; FIFO_wrfull = vecs[i].full;
      tick_chk();
      check($sformatf("v%0d_wrreq", i), FIFO_wrreq, vecs[i].wrreq);
      check($sformatf("v%0d_data", i), FIFO_data, vecs[i].data);
      check($sformatf("v%0d_trig", i), triggered, vecs[i].trig);
      check($sformatf("v%0d_state", i), state_debug, vecs[i].st);
    end

    // Unmasked channels 1/2 toggle for 100 cycles: nothing may happen.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk) probe_in = {~probe_in[2], ~probe_in[1], 1'b0};
      tick_chk();
      check("unmasked_quiet", {FIFO_wrreq, triggered, state_debug}, {1'b0, 1'b0, 2'd1});
    end

    // Falling edge on channel 0: write appears after the third edge.
    @(negedge clk) probe_in = 3'b001;
    repeat (4) tick_chk();
    check("fall_pre_state", state_debug, 1);
    @(negedge clk) probe_in = 3'b000;
    tick_chk(); check("fall_lat1", FIFO_wrreq, 0);
    tick_chk(); check("fall_lat2", FIFO_wrreq, 0);
    tick_chk();
    check("fall_wrreq", FIFO_wrreq, 1);
    check("fall_data", FIFO_data, 0);
    check("fall_trig", triggered, 1);
    check("fall_state", state_debug, 2);

    // Full rises mid-cycle: write request drops combinationally, then DONE.
    @(negedge clk) FIFO_wrfull = 1'b1;
    #1 check("full_comb", FIFO_wrreq, 0);
    tick_chk(); check("full_done", state_debug, 3);
    @(negedge clk) FIFO_wrfull = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick_chk();
      check("done_nowrite", {FIFO_wrreq, state_debug}, {1'b0, 2'd3});
    end

    // Disarm collides with a masked rising edge on channel 0.
    @(negedge clk) Syncrst = 1'b1;
    tick_chk(); check("disarm_state", state_debug, 0);
    @(negedge clk) begin Syncrst = 1'b0; Mask = 3'b001; Trig_Falling = 1'b0; end
    tick_chk(); check("rearm_state", state_debug, 1);
    @(negedge clk) probe_in = 3'b001;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk) Syncrst = 1'b1;
    tick_chk();
    check("ovr_state", state_debug, 0);
    check("ovr_trig", triggered, 0);
    check("ovr_wrreq", FIFO_wrreq, 0);
    @(negedge clk) Syncrst = 1'b0;
    tick_chk(); check("ovr_rearm", state_debug, 1);
    @(negedge clk) probe_in = 3'b000;
    repeat (3) tick_chk();
    check("ovr_fall_ignored", state_debug, 1);
    @(negedge clk) probe_in = 3'b001;
    tick_chk(); check("ovr_lat1", FIFO_wrreq, 0);
    tick_chk(); check("ovr_lat2", FIFO_wrreq, 0);
    tick_chk();
    check("ovr_wrreq2", FIFO_wrreq, 1);
    check("ovr_data2", FIFO_data, 3'b001);
    check("ovr_trig2", triggered, 1);
    check("ovr_state2", state_debug, 2);
    tick_chk(); check("stream_wrreq", FIFO_wrreq, 1);

    // Async reset between edges clears outputs without a clock.
    @(posedge clk);
    #3 begin rst = 1'b1; Syncrst = 1'b1; end
    #1;
    check("arst_wrreq", FIFO_wrreq, 0);
    check("arst_data", FIFO_data, 0);
    check("arst_trig", triggered, 0);
    check("arst_state", state_debug, 0);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick_chk();
      check("arst_hold", {FIFO_wrreq, state_debug}, {1'b0, 2'd0});
    end

    // Mask==0 gives an immediate trigger and one write per clock.
    @(negedge clk) begin Syncrst = 1'b0; Mask = 3'b000; end
    tick_chk(); check("free_armed", state_debug, 1);
    tick_chk();
    check("free_trig", {FIFO_wrreq, triggered, state_debug}, {1'b1, 1'b1, 2'd2});
    for (int i = 0; i < 3; i++) begin
      tick_chk();
      check("free_stream", FIFO_wrreq, 1);
    end

`ifdef CAPTURE_SAMPLE_DIV_EN
    // Div_Value=3: writes every 4 clocks; mid-capture change is ignored.
    @(negedge clk) Syncrst = 1'b1;
    tick_chk();
    @(negedge clk) begin Syncrst = 1'b0; Div_Value = 16'd3; end
    tick_chk(); check("div_armed", state_debug, 1);
    tick_chk(); check("div_first", FIFO_wrreq, 1);
    for (int c = 1; c <= 12; c++) begin
      if (c == 5) @(negedge clk) Div_Value = 16'd0;
      tick_chk();
      check($sformatf("div_c%0d", c), FIFO_wrreq, (c % 4) == 0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
